// File: rtl/storer.sv
// Result store engine: reads N_OUT words from the result register file and
// writes each one to consecutive SRAM addresses using a SETUP/PULSE/HOLD strobe.
module storer #(
    parameter int          R_ADDR_W          = 4,
    parameter logic [16:0] ADDR_OUTPUT_START = 17'h10000,
    parameter int          N_OUT             = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [15:0]         y_rd,
    output logic [R_ADDR_W-1:0] y_ra,
    output logic                y_re,
    output logic [16:0]         sram_addr,
    output logic [15:0]         sram_data_out,
    output logic                sram_data_output_en,
    output logic                sram_cs_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                fin
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [R_ADDR_W-1:0] idx;
        logic [R_ADDR_W-1:0] y_ra;
        logic                y_re;
        logic [16:0]         addr;
        logic [15:0]         data;
        logic                oe_en;
        logic                cs_n;
        logic                oe_n;
        logic                we_n;
        logic                fin;
    } regs_t;

    localparam logic [R_ADDR_W-1:0] IDX_ZERO = {R_ADDR_W{1'b0}};
    localparam logic [R_ADDR_W-1:0] IDX_ONE  = {{(R_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [R_ADDR_W-1:0] IDX_LAST = R_ADDR_W'(N_OUT - 1);

    // Idle/abort values: chip selected, bus released, write strobe inactive.
    localparam regs_t REGS_RST = '{
        idx:   IDX_ZERO,
        y_ra:  IDX_ZERO,
        y_re:  1'b0,
        addr:  17'h00000,
        data:  16'h0000,
        oe_en: 1'b0,
        cs_n:  1'b0,
        oe_n:  1'b0,
        we_n:  1'b1,
        fin:   1'b0
    };

    state_t              state_q, state_d;
    regs_t               r_q, r_d;
    logic [R_ADDR_W-1:0] idx_inc_s;
    logic [16:0]         word_addr_s;

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        idx_inc_s   = r_q.idx + IDX_ONE;
        word_addr_s = ADDR_OUTPUT_START + {{(17-R_ADDR_W){1'b0}}, r_q.idx};
        case (state_q)
            ST_IDLE: begin
                r_d = REGS_RST;
                if (run) begin
                    state_d  = ST_RD;
                    r_d.y_re = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    r_d     = REGS_RST;
                end else begin
                    state_d  = ST_SETUP;
                    r_d.y_re = 1'b0;
                end
            end
            ST_SETUP: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    r_d     = REGS_RST;
                end else begin
                    state_d   = ST_PULSE;
                    r_d.data  = y_rd;
                    r_d.addr  = word_addr_s;
                    r_d.oe_en = 1'b1;
                    r_d.oe_n  = 1'b1;
                    r_d.we_n  = 1'b1;
                end
            end
            ST_PULSE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    r_d     = REGS_RST;
                end else begin
                    state_d  = ST_HOLD;
                    r_d.we_n = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    r_d     = REGS_RST;
                end else if (r_q.idx != IDX_LAST) begin
                    state_d  = ST_RD;
                    r_d.we_n = 1'b1;
                    r_d.idx  = idx_inc_s;
                    r_d.y_ra = idx_inc_s;
                    r_d.y_re = 1'b1;
                end else begin
                    state_d  = ST_DONE;
                    r_d.we_n = 1'b1;
                end
            end
            ST_DONE: begin
                // Bus is released and fin raised on the first DONE edge, then held.
                if (run) begin
                    state_d   = ST_DONE;
                    r_d.fin   = 1'b1;
                    r_d.oe_en = 1'b0;
                    r_d.oe_n  = 1'b0;
                    r_d.addr  = 17'h00000;
                end else begin
                    state_d = ST_IDLE;
                    r_d     = REGS_RST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                r_d     = REGS_RST;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_q     <= REGS_RST;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    assign y_ra                = r_q.y_ra;
    assign y_re                = r_q.y_re;
    assign sram_addr           = r_q.addr;
    assign sram_data_out       = r_q.data;
    assign sram_data_output_en = r_q.oe_en;
    assign sram_cs_n           = r_q.cs_n;
    assign sram_oe_n           = r_q.oe_n;
    assign sram_we_n           = r_q.we_n;
    assign fin                 = r_q.fin;

endmodule

// File: tb/tb_storer.sv
// Self-checking bench for storer: register-file and SRAM models, random data,
// abort and reset-mid-run scenarios, and per-cycle bus invariants.
module tb_storer;

    localparam logic [16:0] START = 17'h10000;

    logic        clk = 1'b0;
    logic        reset, run0, run1;
    logic [15:0] y_rd0, y_rd1;
    logic [3:0]  y_ra0, y_ra1;
    logic        y_re0, y_re1;
    logic [16:0] addr0, addr1;
    logic [15:0] data0, data1;
    logic        oe_en0, oe_en1, cs_n0, cs_n1, oe_n0, oe_n1, we_n0, we_n1, fin0, fin1;

    storer #(.ADDR_OUTPUT_START(START), .N_OUT(10)) dut (
        .clk(clk), .reset(reset), .run(run0), .y_rd(y_rd0), .y_ra(y_ra0), .y_re(y_re0),
        .sram_addr(addr0), .sram_data_out(data0), .sram_data_output_en(oe_en0),
        .sram_cs_n(cs_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0), .fin(fin0)
    );

    storer #(.ADDR_OUTPUT_START(START), .N_OUT(1)) dut1 (
        .clk(clk), .reset(reset), .run(run1), .y_rd(y_rd1), .y_ra(y_ra1), .y_re(y_re1),
        .sram_addr(addr1), .sram_data_out(data1), .sram_data_output_en(oe_en1),
        .sram_cs_n(cs_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1), .fin(fin1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int viol     = 0;
    int wc0      = 0;
    int wc1      = 0;
    logic [15:0] rf0 [16];
    logic [15:0] rf1 [16];
    logic [15:0] mem0 [int];
    logic [15:0] mem1 [int];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        if (y_re0 === 1'b1) y_rd0 <= rf0[y_ra0];
        if (y_re1 === 1'b1) y_rd1 <= rf1[y_ra1];
    end

    // SRAM model and bus invariants, sampled mid-cycle.
    logic        pwe0 = 1'b1, poe0 = 1'b0, pwe1 = 1'b1;
    logic [16:0] paddr0 = 17'h0;
    logic [15:0] pdata0 = 16'h0;
    always @(negedge clk) begin
        if (oe_en0 === 1'b1 && oe_n0 !== 1'b1) viol++;
        if (cs_n0 === 1'b1) viol++;
        if (we_n0 === 1'b0 && pwe0 === 1'b0) viol++;
        if (oe_en0 === 1'b1 && (addr0 < START || addr0 > START + 17'd9)) viol++;
        if (y_re0 === 1'b1 && y_ra0 > 4'd9) viol++;
        if (we_n0 === 1'b0 && !(poe0 === 1'b1 && paddr0 === addr0 && pdata0 === data0)) viol++;
        if (pwe0 === 1'b0 && oe_en0 === 1'b1 && (paddr0 !== addr0 || pdata0 !== data0)) viol++;
        if (we_n0 === 1'b0) begin
            mem0[int'(addr0)] = data0;
            wc0++;
        end
        pwe0 = we_n0; poe0 = oe_en0; paddr0 = addr0; pdata0 = data0;
        if (oe_en1 === 1'b1 && oe_n1 !== 1'b1) viol++;
        if (cs_n1 === 1'b1) viol++;
        if (we_n1 === 1'b0 && pwe1 === 1'b0) viol++;
        if (we_n1 === 1'b0) begin
            mem1[int'(addr1)] = data1;
            wc1++;
        end
        pwe1 = we_n1;
    end

    function automatic logic [63:0] pack0();
        return {22'h0, addr0, data0, oe_en0, cs_n0, oe_n0, we_n0, y_ra0, y_re0, fin0};
    endfunction
    localparam logic [63:0] RST_PACK = {22'h0, 17'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};

    // Raises run at the current negedge (next posedge is edge 0) and reports the fin edge.
    task automatic run_pass(input bit which, output int fin_edge);
        fin_edge = -1;
        if (which) run1 = 1'b1; else run0 = 1'b1;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            if ((which ? fin1 : fin0) === 1'b1) begin
                fin_edge = e;
                break;
            end
        end
    endtask

    task automatic clear0(input bit pattern);
        mem0.delete();
        wc0 = 0;
        for (int i = 0; i < 16; i++) rf0[i] = pattern ? (16'hA000 + 16'(i)) : 16'($urandom);
    endtask

    task automatic verify0(input string tag, input int fe);
        check_eq({tag, "_fin_edge"}, 64'(fe), 64'd41);
        check_eq({tag, "_we_pulses"}, 64'(wc0), 64'd10);
        check_eq({tag, "_nwords"}, 64'(mem0.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            int a = int'(START) + i;
            check_eq($sformatf("%s_w%0d", tag, i),
                     mem0.exists(a) ? 64'(mem0[a]) : 64'hDEAD_BEEF, 64'(rf0[i]));
        end
    endtask

    task automatic wait_word(input int w, output bit found);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (we_n0 === 1'b0 && addr0 === START + 17'(w)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  fe;
        bit  found;
        int  fin_low;
        reset = 1'b1; run0 = 1'b0; run1 = 1'b0;
        for (int i = 0; i < 16; i++) begin rf0[i] = 16'h0; rf1[i] = 16'h0; end
        repeat (3) @(negedge clk);
        check_eq("reset_state", pack0(), RST_PACK);
        check_eq("reset_fin1", 64'(fin1), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fixed pattern pass followed by random passes, 1-cycle run gap between them.
        for (int p = 0; p < 4; p++) begin
            clear0(p == 0);
            run_pass(1'b0, fe);
            verify0($sformatf("pass%0d", p), fe);
            run0 = 1'b0;
            @(negedge clk);
            check_eq($sformatf("pass%0d_fin_clear", p), 64'(fin0), 64'd0);
        end

        // Single-word instance; fin must persist without extra writes.
        rf1[0] = 16'h1234; mem1.delete(); wc1 = 0;
        run_pass(1'b1, fe);
        check_eq("n1_fin_edge", 64'(fe), 64'd5);
        check_eq("n1_word", mem1.exists(int'(START)) ? 64'(mem1[int'(START)]) : 64'hDEAD_BEEF, 64'h1234);
        fin_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (fin1 !== 1'b1) fin_low++;
        end
        check_eq("n1_fin_held", 64'(fin_low), 64'd0);
        check_eq("n1_we_pulses", 64'(wc1), 64'd1);
        run1 = 1'b0;
        @(negedge clk);

        // Abort during the write pulse of word 3.
        clear0(1'b0);
        run0 = 1'b1;
        wait_word(3, found);
        check_eq("abort_reach", 64'(found), 64'd1);
        run0 = 1'b0;
        @(negedge clk);
        check_eq("abort_outputs", pack0(), RST_PACK);
        repeat (10) @(negedge clk);
        check_eq("abort_we_pulses", 64'(wc0), 64'd4);
        check_eq("abort_nwords", 64'(mem0.size()), 64'd4);
        clear0(1'b0);
        run_pass(1'b0, fe);
        verify0("after_abort", fe);
        run0 = 1'b0;
        @(negedge clk);

        // Reset in the cycle after word 5 is strobed.
        clear0(1'b0);
        run0 = 1'b1;
        wait_word(5, found);
        check_eq("reset_reach", 64'(found), 64'd1);
        @(negedge clk);
        reset = 1'b1; run0 = 1'b0;
        @(negedge clk);
        check_eq("midrun_reset", pack0(), RST_PACK);
        reset = 1'b0;
        @(negedge clk);
        clear0(1'b0);
        run_pass(1'b0, fe);
        verify0("after_reset", fe);
        run0 = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("invariants", 64'(viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
